// File: rtl/fp32_normalize_round_pack.sv
// Final binary32 add/sub stage: classify the raw sum, then normalize, round to
// nearest-even and pack, with overflow saturation and flush-to-zero underflow.
module fp32_normalize_round_pack #(
  parameter bit FTZ_KEEP_SIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        valid_in,
  input  logic        sign,
  input  logic [7:0]  exponent,
  input  logic [24:0] adder_value,
  output logic        valid_out,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

  logic [1:0]  vld_pipe;

  logic        r_s1_sign;
  logic [7:0]  r_s1_exp;
  logic [24:0] r_s1_val;
  logic        r_s1_carry;
  logic        r_s1_zero;
  logic [4:0]  r_s1_lz;

  logic [31:0] r_result;
  logic        r_ovf;
  logic        r_unf;

  logic [4:0]         w_lz;
  logic [24:0]        w_rnd;
  logic [23:0]        w_m;
  logic signed [9:0]  w_e;
  logic [31:0]        w_res;
  logic               w_ovf;
  logic               w_unf;

  // Leading-zero count of the hidden-bit field; highest set bit wins.
  always_comb begin
    w_lz = 5'd0;
    for (int i = 0; i < 24; i++)
      if (adder_value[i]) w_lz = 5'(23 - i);
  end

  always_comb begin
    w_rnd = {1'b0, r_s1_val[24:1]} + {24'b0, r_s1_val[0] & r_s1_val[1]};
    w_m   = r_s1_val[23:0] << r_s1_lz;
    w_e   = $signed({2'b00, r_s1_exp}) - $signed({5'b00000, r_s1_lz});
    if (r_s1_carry) begin
      // Only one bit is dropped, so a set guard is always a tie: round to even.
      if (w_rnd[24]) begin
        w_m = w_rnd[24:1];
        w_e = $signed({2'b00, r_s1_exp}) + 10'sd2;
      end else begin
        w_m = w_rnd[23:0];
        w_e = $signed({2'b00, r_s1_exp}) + 10'sd1;
      end
    end
    w_res = 32'h0;
    w_ovf = 1'b0;
    w_unf = 1'b0;
    if (r_s1_zero) begin
      w_res = 32'h0;
    end else if (w_e >= 10'sd255) begin
      w_res = {r_s1_sign, 8'hFF, 23'h0};
      w_ovf = 1'b1;
    end else if (w_e <= 10'sd0) begin
      w_res = {FTZ_KEEP_SIGN ? r_s1_sign : 1'b0, 31'h0};
      w_unf = 1'b1;
    end else begin
      w_res = {r_s1_sign, w_e[7:0], w_m[22:0]};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe   <= 2'b00;
      r_s1_sign  <= 1'b0;
      r_s1_exp   <= 8'h0;
      r_s1_val   <= 25'h0;
      r_s1_carry <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_lz    <= 5'd0;
      r_result   <= 32'h0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[0], valid_in};
      if (valid_in) begin
        r_s1_sign  <= sign;
        r_s1_exp   <= exponent;
        r_s1_val   <= adder_value;
        r_s1_carry <= adder_value[24];
        r_s1_zero  <= (adder_value == 25'h0);
        r_s1_lz    <= w_lz;
      end
      if (vld_pipe[0]) begin
        r_result <= w_res;
        r_ovf    <= w_ovf;
        r_unf    <= w_unf;
      end
    end
  end

  assign valid_out = vld_pipe[1];
  assign result    = r_result;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: doc/fp32_normalize_round_pack.md
Name: fp32_normalize_round_pack

Overview:
Final stage of the binary32 floating-point adder/subtractor. It sits directly downstream of the mantissa add/sub stage, which produces sign, valid and a 25-bit magnitude sum. The exponent of the larger operand is carried alongside from the alignment stage. This block normalizes the sum (carry-out right shift or leading-zero left shift), adjusts the exponent, rounds to nearest-even, handles zero/overflow/underflow, and packs an IEEE-754 binary32 word.

Parameters:
FTZ_KEEP_SIGN, 1, on exponent underflow flush to zero: 1 = keep input sign, 0 = force +0

Ports:
clk  input  1  system clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
valid_in  input  1  sign/exponent/adder_value are valid this cycle
sign  input  1  result sign from add/sub stage
exponent  input  8  biased exponent of larger-magnitude operand (1..254)
adder_value  input  25  unsigned magnitude; bit 24 = carry-out, bit 23 = hidden-bit position
valid_out  output  1  result/flags valid
result  output  32  packed binary32 {sign, exp[7:0], frac[22:0]}
overflow  output  1  result saturated to infinity
underflow  output  1  result flushed to zero

Behaviour:
- Reset (async, rstn=0): valid_out, result, overflow and underflow are all 0. All internal pipeline registers are 0. Reset mid-operation discards in-flight data; no valid_out is produced for items sampled before reset.
- Pipeline has 2 register stages, throughput 1 per cycle, no back-pressure.
  - valid_out(n+2) = valid_in(n).
  - Valid bits shift every cycle.
  - Data registers of a stage load only when that stage's incoming valid is 1; otherwise they hold. Outputs therefore hold their last value while valid_out=0.
- Stage 1 (classify): register sign, exponent, adder_value and:
  - carry = adder_value[24]
  - is_zero = (adder_value == 0)
  - lz = leading-zero count of adder_value[23:0], range 0..23, don't-care when is_zero.
- Stage 2 (normalize/round/pack), using a 10-bit signed exponent arithmetic to detect range:
  - is_zero: result = 32'h00000000 (+0 regardless of sign, exact cancellation); overflow=0; underflow=0.
  - carry=1:
    - m = adder_value[24:1], g = adder_value[0], e = exponent+1.
    - Round to nearest-even: increment m iff g=1 and m[0]=1 (single dropped bit, so g=1 is always a tie).
    - If the increment gives m = 2^24: m = m>>1, e = e+1.
  - carry=0: m = adder_value[23:0] << lz, e = exponent - lz. The result is exact, no rounding.
  - If e >= 255: result = {sign, 8'hFF, 23'h0}, overflow=1.
  - If e <= 0: result = {FTZ_KEEP_SIGN ? sign : 0, 31'h0}, underflow=1.
  - Else: result = {sign, e[7:0], m[22:0]}; overflow=0, underflow=0.
  - overflow and underflow are mutually exclusive. They update only with a valid stage-2 load.
- Exponent input 0 or 255 (denormal/special) is outside this block's contract; the upstream stage handles specials. Output for such inputs is unspecified, but no X propagation is permitted.

Test Plan:
- Reset then 1.0+1.0 (sign 0, exponent 127, adder_value 25'h1000000) -> 2 cycles later valid_out=1, result 32'h40000000, flags 0.
- Cancellation shift: exponent 127, adder_value 25'h0200000, sign 0 -> lz=2, result 32'h3E800000. Also adder_value 0 with sign 1 -> result 32'h00000000.
- Rounding: exponent 127, adder_value 25'h1FFFFFF -> double renormalization, result 32'h40800000. Exponent 127, adder_value 25'h1000001 (tie, even lsb) -> 32'h40000000. Exponent 127, adder_value 25'h1000003 -> 32'h40000002.
- Range: exponent 254, adder_value 25'h1000000 -> 32'h7F800000, overflow=1. Exponent 1, adder_value 25'h0400000, sign 1 -> 32'h80000000, underflow=1 (FTZ_KEEP_SIGN=1).
- Streaming/hold: 4 back-to-back valid inputs then valid_in=0 for 3 cycles -> 4 consecutive valid_out pulses in order, after which result holds the last value. Bubble pattern 1,0,1 is reproduced exactly 2 cycles later.
- Reset mid-stream: assert rstn=0 with 2 items in flight -> outputs zero immediately, no stale valid_out after release.
